pwm_multi_gen: RTL and testbench

Multi-channel PWM generator with a programmable period, per-channel duty, edge- or centre-aligned counting, and glitch-free shadowed reconfiguration. One shared timebase counter drives CH compare channels. New settings are captured through a valid/ready handshake and take effect only at a period boundary. It is the parametrised successor to the single-channel fixed-period duty-cycle generator, and feeds motor/LED drive logic.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_compare_ch.sv | 30 +++
 rtl/pwm_multi_gen.sv | 143 ++++++++++++++
 tb/tb_pwm_multi_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types for the multi-channel PWM generator
//
// Provides the counting-mode enum and a default-sized configuration record
// used by the shadow/active register pair.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    localparam int PWM_DEF_CH = 4;
    localparam int PWM_DEF_W  = 8;

    // Configuration record at the default channel count and width.
    typedef struct packed {
        pwm_mode_e                          mode;
        logic [PWM_DEF_W-1:0]               period;
        logic [PWM_DEF_CH*PWM_DEF_W-1:0]    duty;
    } pwm_cfg_t;

endpackage

// File: rtl/pwm_compare_ch.sv
// rtl/pwm_compare_ch.sv - registered per-channel duty comparator
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run enable; low forces the output low
//   cnt        : shared timebase value
//   duty       : active duty threshold for this channel
//   pwm_out    : registered (en && cnt < duty)
module pwm_compare_ch
    import pwm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] cnt,
    input  logic [W-1:0] duty,
    output logic         pwm_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= en && (cnt < duty);
        end
    end

endmodule

// File: rtl/pwm_multi_gen.sv
// rtl/pwm_multi_gen.sv - multi-channel PWM with shadowed, boundary-applied config
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   en            : run enable; low holds cnt at 0 and forces outputs low
//   cfg_valid     : configuration offered
//   cfg_ready     : shadow register free (inverse of cfg_pending)
//   cfg_mode      : 0 = edge-aligned, 1 = centre-aligned
//   cfg_period    : terminal count P
//   cfg_duty      : packed duties, channel i at [i*W +: W]
//   cfg_pending   : shadow holds a config not yet applied
//   pwm_out       : PWM outputs, one per channel
//   period_start  : one-cycle pulse on the first output cycle of each period
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int CH = 4,
    parameter int W  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic            cfg_mode,
    input  logic [W-1:0]    cfg_period,
    input  logic [CH*W-1:0] cfg_duty,
    output logic            cfg_pending,
    output logic [CH-1:0]   pwm_out,
    output logic            period_start
);

    // Sized locally so non-default CH/W instances stay consistent.
    typedef struct packed {
        pwm_mode_e          mode;
        logic [W-1:0]       period;
        logic [CH*W-1:0]    duty;
    } cfg_t;

    // Direction FSM. DOWN covers cnt = P down to 1 in centre mode, so the
    // top count is entered already facing downward.
    localparam logic [0:0] ST_UP   = 1'b0;
    localparam logic [0:0] ST_DOWN = 1'b1;

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    logic [W-1:0] cnt_inc;
    logic [0:0]   dir;
    logic [0:0]   dir_nxt;
    logic         boundary;
    logic         apply;
    logic         accept;
    cfg_t         act_cfg;
    cfg_t         shadow_cfg;

    assign cfg_ready = !cfg_pending;
    assign accept    = cfg_valid && !cfg_pending;
    assign cnt_inc   = cnt + 1'b1;

    // With the enable low there is no period to protect, so a pending
    // config is taken straight away.
    assign apply = cfg_pending && (boundary || !en);

    always_comb begin
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        boundary = 1'b0;
        if (!en) begin
            cnt_nxt = '0;
            dir_nxt = ST_UP;
        end else if (act_cfg.mode == PWM_EDGE) begin
            dir_nxt = ST_UP;
            if (cnt == act_cfg.period) begin
                boundary = 1'b1;
                cnt_nxt  = '0;
            end else begin
                cnt_nxt = cnt_inc;
            end
        end else if (act_cfg.period == '0) begin
            // Degenerate centre period: cnt pinned at 0, every cycle a boundary.
            boundary = 1'b1;
            cnt_nxt  = '0;
            dir_nxt  = ST_UP;
        end else if (dir == ST_UP) begin
            cnt_nxt = cnt_inc;
            dir_nxt = (cnt_inc == act_cfg.period) ? ST_DOWN : ST_UP;
        end else begin
            if (cnt == W'(1)) begin
                boundary = 1'b1;
                cnt_nxt  = '0;
                dir_nxt  = ST_UP;
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end

        if (apply) begin
            cnt_nxt = '0;
            dir_nxt = ST_UP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            dir          <= ST_UP;
            act_cfg      <= '0;
            shadow_cfg   <= '0;
            cfg_pending  <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            dir          <= dir_nxt;
            // cnt is 0 only on the first cycle of a period in either mode.
            period_start <= en && (cnt == '0);
            // accept requires !cfg_pending and apply requires cfg_pending,
            // so a config taken at a boundary waits for the next one.
            if (apply) begin
                act_cfg     <= shadow_cfg;
                cfg_pending <= 1'b0;
            end else if (accept) begin
                shadow_cfg.mode   <= pwm_mode_e'(cfg_mode);
                shadow_cfg.period <= cfg_period;
                shadow_cfg.duty   <= cfg_duty;
                cfg_pending       <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        pwm_compare_ch #(
            .W(W)
        ) u_cmp (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .cnt     (cnt),
            .duty    (act_cfg.duty[i*W +: W]),
            .pwm_out (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb/tb_pwm_multi_gen.sv - self-checking bench for pwm_multi_gen
module tb_pwm_multi_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        cfg_mode = 1'b0;
    logic [7:0]  cfg_period = '0;
    logic [31:0] cfg_duty = '0;
    logic        cfg_pending;
    logic [3:0]  pwm_out;
    logic        period_start;

    int checks = 0;
    int errors = 0;

    pwm_multi_gen #(.CH(4), .W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_mode     (cfg_mode),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .cfg_pending  (cfg_pending),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    // Reference model: position k within the current period, with cnt
    // derived from k by the period shape of the active mode.
    int m_k;
    bit m_pend;
    bit m_act_mode, m_sh_mode;
    int m_act_p, m_sh_p;
    int m_act_d[4];
    int m_sh_d[4];

    function automatic void m_reset();
        m_k = 0; m_pend = 0;
        m_act_mode = 0; m_sh_mode = 0; m_act_p = 0; m_sh_p = 0;
        for (int i = 0; i < 4; i++) begin
            m_act_d[i] = 0; m_sh_d[i] = 0;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        int len, c;
        logic [3:0] ep;
        logic eps;
        bit app, acc;
        @(posedge clk);
        if (m_act_mode) len = (m_act_p == 0) ? 1 : 2 * m_act_p;
        else            len = m_act_p + 1;
        c = (m_act_mode && m_k > m_act_p) ? 2 * m_act_p - m_k : m_k;
        for (int i = 0; i < 4; i++) ep[i] = en && (c < m_act_d[i]);
        eps = en && (m_k == 0);
        app = m_pend && (!en || m_k == len - 1);
        acc = cfg_valid && !m_pend;
        if (!en || m_k == len - 1) m_k = 0;
        else m_k++;
        if (app) begin
            m_act_mode = m_sh_mode; m_act_p = m_sh_p;
            for (int i = 0; i < 4; i++) m_act_d[i] = m_sh_d[i];
            m_pend = 0; m_k = 0;
        end
        if (acc) begin
            m_sh_mode = cfg_mode; m_sh_p = int'(cfg_period);
            for (int i = 0; i < 4; i++) m_sh_d[i] = int'(cfg_duty[i*8 +: 8]);
            m_pend = 1;
        end
        #1;
        chk("pwm_out", {28'd0, pwm_out}, {28'd0, ep});
        chk("period_start", {31'd0, period_start}, {31'd0, eps});
        chk("cfg_pending", {31'd0, cfg_pending}, {31'd0, m_pend});
        chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_pend});
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        #1;
        m_reset();
        #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic            mode;
        logic [7:0]      period;
        logic [31:0]     duty;
        int              ncyc;
        logic [3:0][15:0] exp_hi;
        int              exp_ps;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input int v);
        int hi[4];
        int ps;
        hard_reset();
        en = 1'b0;
        cfg_mode = vecs[v].mode; cfg_period = vecs[v].period; cfg_duty = vecs[v].duty;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        en = 1'b1;
        ps = 0;
        for (int i = 0; i < 4; i++) hi[i] = 0;
        for (int n = 0; n < vecs[v].ncyc; n++) begin
            tick();
            for (int i = 0; i < 4; i++) hi[i] += int'(pwm_out[i]);
            ps += int'(period_start);
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("vec%0d_hi_ch%0d", v, i), hi[i], {16'd0, vecs[v].exp_hi[i]});
        chk($sformatf("vec%0d_ps", v), ps, vecs[v].exp_ps);
    endtask

    initial begin
        int n, hi;
        m_reset();
        // {mode, P, duty {ch3,ch2,ch1,ch0}, cycles, highs {ch3..ch0}, period_starts}
        vecs[0] = '{1'b0, 8'd4,   {8'd7, 8'd5, 8'd2, 8'd0},     10,
                    {16'd10, 16'd10, 16'd4, 16'd0}, 2};
        vecs[1] = '{1'b1, 8'd4,   {8'd5, 8'd4, 8'd0, 8'd2},     16,
                    {16'd16, 16'd14, 16'd0, 16'd6}, 2};
        vecs[2] = '{1'b0, 8'd0,   {8'd255, 8'd1, 8'd1, 8'd0},   6,
                    {16'd6, 16'd6, 16'd6, 16'd0}, 6};
        vecs[3] = '{1'b1, 8'd1,   {8'd1, 8'd0, 8'd2, 8'd1},     8,
                    {16'd4, 16'd0, 16'd8, 16'd4}, 4};
        vecs[4] = '{1'b0, 8'd255, {8'd0, 8'd1, 8'd255, 8'd128}, 256,
                    {16'd0, 16'd1, 16'd255, 16'd128}, 1};

        #1;
        chk("rst_pwm_out", {28'd0, pwm_out}, 32'd0);
        chk("rst_period_start", {31'd0, period_start}, 32'd0);
        chk("rst_cfg_pending", {31'd0, cfg_pending}, 32'd0);
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        #2;
        rst_n = 1'b1;

        for (int v = 1; v < 5; v++) run_vec(v);
        run_vec(0);

        // Mid-period reconfig P 4 -> 9 accepted at cnt = 1.
        n = 0;
        while (!period_start && n < 20) begin tick(); n++; end
        chk("reconf_find_ps", {31'd0, period_start}, 32'd1);
        cfg_mode = 1'b0; cfg_period = 8'd9; cfg_duty = {8'd6, 8'd6, 8'd6, 8'd6};
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("reconf_pending", {31'd0, cfg_pending}, 32'd1);
        n = 1;
        while (!period_start && n < 30) begin tick(); n++; end
        chk("reconf_old_len", n, 5);
        hi = int'(pwm_out[1]);
        for (int i = 0; i < 9; i++) begin tick(); hi += int'(pwm_out[1]); end
        chk("reconf_new_hi", hi, 6);
        tick();
        chk("reconf_new_len", {31'd0, period_start}, 32'd1);

        // Mode switch while pending with a second offer held on cfg_valid.
        cfg_mode = 1'b1; cfg_period = 8'd3; cfg_duty = {8'd2, 8'd1, 8'd3, 8'd2};
        cfg_valid = 1'b1;
        tick();
        cfg_mode = 1'b0; cfg_period = 8'd6; cfg_duty = {8'd3, 8'd7, 8'd0, 8'd3};
        n = 0;
        while (cfg_pending && n < 30) begin tick(); n++; end
        chk("stall_released", {31'd0, cfg_pending}, 32'd0);
        tick();
        chk("stall_reaccept", {31'd0, cfg_pending}, 32'd1);
        cfg_valid = 1'b0;
        for (int i = 0; i < 30; i++) tick();

        // en dropped with a pending config.
        cfg_mode = 1'b0; cfg_period = 8'd5; cfg_duty = {8'd1, 8'd1, 8'd1, 8'd1};
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        en = 1'b0;
        tick();
        chk("endrop_pwm", {28'd0, pwm_out}, 32'd0);
        chk("endrop_applied", {31'd0, cfg_pending}, 32'd0);
        tick(); tick();
        en = 1'b1;
        tick();
        chk("enrise_ps", {31'd0, period_start}, 32'd1);
        chk("enrise_pwm", {28'd0, pwm_out}, 32'hf);
        for (int i = 0; i < 8; i++) tick();

        // Asynchronous reset with a pending config.
        cfg_period = 8'd7; cfg_duty = {8'd4, 8'd4, 8'd4, 8'd4};
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("rstmid_pending_before", {31'd0, cfg_pending}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_pwm", {28'd0, pwm_out}, 32'd0);
        chk("rstmid_ps", {31'd0, period_start}, 32'd0);
        chk("rstmid_pending", {31'd0, cfg_pending}, 32'd0);
        m_reset();
        #2;
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            hi += (pwm_out != 4'd0) ? 1 : 0;
        end
        chk("rstmid_stays_low", hi, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 19) != 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_mode = 1'($urandom_range(0, 1));
            cfg_period = 8'($urandom_range(0, 12));
            for (int c = 0; c < 4; c++) cfg_duty[c*8 +: 8] = 8'($urandom_range(0, 14));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
